// File: rtl/cp0_unit_if.sv
// CP0 register-file bus: mfc0/mtc0 access, victim context and exception request.
interface cp0_unit_if;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        We;
  logic [31:0] PC;
  logic        BD;
  logic [4:0]  ExcCode;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic [31:0] DOut;
  logic [31:0] EPCOut;
  logic        IntReq;

  modport master (
    output A1, A2, DIn, We, PC, BD, ExcCode, HWInt, EXLClr,
    input  DOut, EPCOut, IntReq
  );

  modport slave (
    input  A1, A2, DIn, We, PC, BD, ExcCode, HWInt, EXLClr,
    output DOut, EPCOut, IntReq
  );
endinterface

// File: rtl/cp0_unit.sv
// MIPS CP0 subset: SR, Cause, EPC, PRId with interrupt/exception request logic.
// Optional Count/Compare timer is built when CP0_TIMER_EN is defined.
module cp0_unit (
  input logic       clk,
  input logic       reset,
  cp0_unit_if.slave bus
);
  localparam logic [4:0]  REG_COUNT   = 5'd9;
  localparam logic [4:0]  REG_COMPARE = 5'd11;
  localparam logic [4:0]  REG_SR      = 5'd12;
  localparam logic [4:0]  REG_CAUSE   = 5'd13;
  localparam logic [4:0]  REG_EPC     = 5'd14;
  localparam logic [4:0]  REG_PRID    = 5'd15;
  localparam logic [31:0] PRID_VALUE  = 32'h1805_0008;

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exccode_q, exccode_d;
  logic [31:2] epc_q, epc_d;

  logic [5:0]  eff_int;
  logic        int_req;
  logic        exc_req;
  logic        take;
  logic        wr_ok;
  logic [31:0] dout;
  logic        pc_low_unused;

  // The victim PC is word-aligned by construction; EPC keeps only bits 31:2.
  assign pc_low_unused = ^bus.PC[1:0];

`ifdef CP0_TIMER_EN
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        tpend_q, tpend_d;

  assign eff_int = {bus.HWInt[5] | tpend_q, bus.HWInt[4:0]};
`else
  assign eff_int = bus.HWInt;
`endif

  assign int_req    = ie_q & ~exl_q & (|(eff_int & im_q));
  assign exc_req    = (bus.ExcCode != 5'd0) & ~exl_q;
  assign take       = int_req | exc_req;
  assign wr_ok      = bus.We & ~take;
  assign bus.IntReq = take;
  assign bus.EPCOut = {epc_q, 2'b00};

  always_comb begin
    im_d      = im_q;
    exl_d     = exl_q;
    ie_d      = ie_q;
    bd_d      = bd_q;
    ip_d      = eff_int;
    exccode_d = exccode_q;
    epc_d     = epc_q;
    if (take) begin
      exl_d     = 1'b1;
      epc_d     = bus.BD ? (bus.PC[31:2] - 30'd1) : bus.PC[31:2];
      bd_d      = bus.BD;
      exccode_d = int_req ? 5'd0 : bus.ExcCode;
    end else begin
      if (bus.EXLClr) exl_d = 1'b0;
      // A software write to EXL in the same cycle as eret wins.
      if (wr_ok) begin
        case (bus.A2)
          REG_SR: begin
            im_d  = bus.DIn[15:10];
            exl_d = bus.DIn[1];
            ie_d  = bus.DIn[0];
          end
          REG_EPC: epc_d = bus.DIn[31:2];
          default: ;
        endcase
      end
    end
  end

`ifdef CP0_TIMER_EN
  always_comb begin
    count_d   = count_q + 32'd1;
    compare_d = compare_q;
    tpend_d   = tpend_q | (count_q == compare_q);
    if (wr_ok) begin
      if (bus.A2 == REG_COUNT) count_d = bus.DIn;
      if (bus.A2 == REG_COMPARE) begin
        compare_d = bus.DIn;
        tpend_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      compare_q <= '0;
      tpend_q   <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      tpend_q   <= tpend_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q      <= '0;
      exl_q     <= 1'b0;
      ie_q      <= 1'b0;
      bd_q      <= 1'b0;
      ip_q      <= '0;
      exccode_q <= '0;
      epc_q     <= '0;
    end else begin
      im_q      <= im_d;
      exl_q     <= exl_d;
      ie_q      <= ie_d;
      bd_q      <= bd_d;
      ip_q      <= ip_d;
      exccode_q <= exccode_d;
      epc_q     <= epc_d;
    end
  end

  always_comb begin
    dout = '0;
    case (bus.A1)
      REG_SR:      dout = {16'd0, im_q, 8'd0, exl_q, ie_q};
      REG_CAUSE:   dout = {bd_q, 15'd0, ip_q, 3'd0, exccode_q, 2'd0};
      REG_EPC:     dout = {epc_q, 2'b00};
      REG_PRID:    dout = PRID_VALUE;
`ifdef CP0_TIMER_EN
      REG_COUNT:   dout = count_q;
      REG_COMPARE: dout = compare_q;
`endif
      default:     dout = '0;
    endcase
  end

  assign bus.DOut = dout;
endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: register-value model checked every cycle plus directed literals.
module tb_cp0_unit;
  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic mon_on;

  cp0_unit_if bus();

  cp0_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state held as full architectural register images.
  logic [31:0] m_sr, m_cause, m_epc;
  logic [31:0] m_count, m_compare;
  logic        m_pend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] m_eff();
    logic [5:0] e;
    e = bus.HWInt;
`ifdef CP0_TIMER_EN
    if (m_pend) e[5] = 1'b1;
`endif
    return e;
  endfunction

  function automatic logic m_int();
    logic [31:0] sr;
    sr = m_sr;
    return sr[0] && !sr[1] && ((m_eff() & sr[15:10]) != 6'd0);
  endfunction

  function automatic logic m_take();
    logic [31:0] sr;
    sr = m_sr;
    return m_int() || (bus.ExcCode != 5'd0 && !sr[1]);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12: return m_sr;
      5'd13: return m_cause;
      5'd14: return m_epc;
      5'd15: return 32'h1805_0008;
`ifdef CP0_TIMER_EN
      5'd9:  return m_count;
      5'd11: return m_compare;
`endif
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin : model
    logic        tk, ti, match;
    logic [31:0] victim, cnt_n;
    if (reset) begin
      m_sr = 0; m_cause = 0; m_epc = 0; m_count = 0; m_compare = 0; m_pend = 0;
    end else begin
      tk    = m_take();
      ti    = m_int();
      match = (m_count == m_compare);
      cnt_n = m_count + 32'd1;
      m_cause = (m_cause & ~32'h0000_FC00) | (32'(m_eff()) << 10);
      if (match) m_pend = 1'b1;
      if (tk) begin
        m_sr    = m_sr | 32'h2;
        victim  = bus.BD ? bus.PC - 32'd4 : bus.PC;
        m_epc   = victim & 32'hFFFF_FFFC;
        m_cause = (m_cause & 32'h7FFF_FF83) | (32'(bus.BD) << 31)
                | ((ti ? 32'd0 : 32'(bus.ExcCode)) << 2);
      end else begin
        if (bus.EXLClr) m_sr = m_sr & ~32'h2;
        if (bus.We) begin
          if (bus.A2 == 5'd12) m_sr  = bus.DIn & 32'h0000_FC03;
          if (bus.A2 == 5'd14) m_epc = bus.DIn & 32'hFFFF_FFFC;
`ifdef CP0_TIMER_EN
          if (bus.A2 == 5'd9) cnt_n = bus.DIn;
          if (bus.A2 == 5'd11) begin
            m_compare = bus.DIn;
            m_pend    = 1'b0;
          end
`endif
        end
      end
      m_count = cnt_n;
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      chk("mdl_intreq", {31'd0, bus.IntReq}, {31'd0, m_take()});
      chk("mdl_epcout", bus.EPCOut, m_epc);
      chk("mdl_dout", bus.DOut, m_read(bus.A1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string name);
    bus.A1 = a;
    #1;
    chk(name, bus.DOut, exp);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.We = 1'b1; bus.A2 = a; bus.DIn = d;
    tick();
    bus.We = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0; mon_on = 1'b0;
    reset = 1'b1;
    bus.A1 = 0; bus.A2 = 0; bus.DIn = 0; bus.We = 0; bus.PC = 0; bus.BD = 0;
    bus.ExcCode = 0; bus.HWInt = 0; bus.EXLClr = 0;
    tick();
    mon_on = 1'b1;
    // Reset must override a concurrent SR write.
    bus.We = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'hFFFF_FFFF;
    tick();
    chk("rst_intreq", {31'd0, bus.IntReq}, 32'd0);
    reset = 1'b0; bus.We = 1'b0;
    rd(5'd15, 32'h1805_0008, "rst_prid");
    rd(5'd12, 32'd0, "rst_sr");
    rd(5'd13, 32'd0, "rst_cause");
    tick();
    rd(5'd14, 32'd0, "rst_epc");
    chk("rst_intreq_idle", {31'd0, bus.IntReq}, 32'd0);

`ifdef CP0_TIMER_EN
    begin : timer_test
      logic seen;
      seen = 1'b0;
      wr(5'd11, 32'd5);
      wr(5'd9, 32'd0);
      wr(5'd12, 32'h0000_8001);
      for (int i = 0; i < 7 && !seen; i++) begin
        #1;
        if (bus.IntReq) seen = 1'b1;
        else tick();
      end
      chk("tmr_fire", {31'd0, seen}, 32'd1);
      tick();
      wr(5'd11, 32'hFFFF_0000);
      bus.EXLClr = 1'b1; tick(); bus.EXLClr = 1'b0;
      #1;
      chk("tmr_clear", {31'd0, bus.IntReq}, 32'd0);
      rd(5'd11, 32'hFFFF_0000, "tmr_compare");
      wr(5'd12, 32'd0);
    end
`else
    wr(5'd9, 32'hFFFF_FFFF);
    wr(5'd11, 32'hFFFF_FFFF);
    rd(5'd9, 32'd0, "no_count");
    rd(5'd11, 32'd0, "no_compare");
`endif

    // Hardware interrupt through IM[0].
    bus.PC = 32'h0000_3000;
    wr(5'd12, 32'h0000_0401);
    bus.HWInt = 6'b000001;
    #1;
    chk("hw_intreq", {31'd0, bus.IntReq}, 32'd1);
    tick();
    bus.HWInt = 6'b000000;
    rd(5'd12, 32'h0000_0403, "hw_sr");
    rd(5'd13, 32'h0000_0400, "hw_cause");
    chk("hw_epc", bus.EPCOut, 32'h0000_3000);

    // Overflow in a delay slot.
    bus.EXLClr = 1'b1; tick(); bus.EXLClr = 1'b0;
    rd(5'd12, 32'h0000_0401, "eret_sr");
    bus.ExcCode = 5'd12; bus.PC = 32'h0000_3010; bus.BD = 1'b1;
    #1;
    chk("ov_intreq", {31'd0, bus.IntReq}, 32'd1);
    tick();
    bus.ExcCode = 5'd0; bus.BD = 1'b0;
    chk("ov_epc", bus.EPCOut, 32'h0000_300C);
    rd(5'd13, 32'h8000_0030, "ov_cause");

    // Pending RI masked by EXL, then taken after eret; exception beats eret.
    tick();
    bus.ExcCode = 5'd10;
    #1;
    chk("ri_masked", {31'd0, bus.IntReq}, 32'd0);
    bus.EXLClr = 1'b1; tick(); bus.EXLClr = 1'b0;
    rd(5'd12, 32'h0000_0401, "ri_sr_exl0");
    chk("ri_intreq", {31'd0, bus.IntReq}, 32'd1);
    bus.PC = 32'h0000_4000; bus.EXLClr = 1'b1;
    tick();
    bus.EXLClr = 1'b0; bus.ExcCode = 5'd0;
    rd(5'd12, 32'h0000_0403, "ri_exl_prio");
    rd(5'd13, 32'h0000_0028, "ri_cause");
    chk("ri_epc", bus.EPCOut, 32'h0000_4000);

    // Exception beats a concurrent mtc0 to EPC.
    bus.EXLClr = 1'b1; tick(); bus.EXLClr = 1'b0;
    bus.ExcCode = 5'd5; bus.PC = 32'h0000_5003;
    bus.We = 1'b1; bus.A2 = 5'd14; bus.DIn = 32'h1234_5678;
    #1;
    chk("ades_intreq", {31'd0, bus.IntReq}, 32'd1);
    tick();
    bus.We = 1'b0; bus.ExcCode = 5'd0;
    chk("ades_epc", bus.EPCOut, 32'h0000_5000);
    rd(5'd13, 32'h0000_0014, "ades_cause");

    // Plain EPC write, no same-cycle bypass.
    bus.EXLClr = 1'b1; tick(); bus.EXLClr = 1'b0;
    bus.We = 1'b1; bus.A2 = 5'd14; bus.DIn = 32'h1234_567B;
    rd(5'd14, 32'h0000_5000, "epc_nobypass");
    chk("epcout_nobypass", bus.EPCOut, 32'h0000_5000);
    tick();
    bus.We = 1'b0;
    chk("epc_written", bus.EPCOut, 32'h1234_5678);

    // Writes to Cause and PRId are ignored.
    wr(5'd13, 32'hFFFF_FFFF);
    wr(5'd15, 32'hFFFF_FFFF);
    rd(5'd13, 32'h0000_0014, "cause_ro");
    rd(5'd15, 32'h1805_0008, "prid_ro");

    // SR write masking, and IP latching while EXL blocks requests.
    wr(5'd12, 32'hFFFF_FFFE);
    rd(5'd12, 32'h0000_FC02, "sr_mask");
    bus.HWInt = 6'b111111;
    #1;
    chk("exl_blocks", {31'd0, bus.IntReq}, 32'd0);
    bus.HWInt = 6'b101010;
    tick();
    bus.HWInt = 6'b000000;
    rd(5'd13, 32'h0000_A814, "ip_latch");

    // IM selects which lines may interrupt.
    wr(5'd12, 32'h0000_8001);
    bus.HWInt = 6'b011111;
    #1;
    chk("im_masked", {31'd0, bus.IntReq}, 32'd0);
    bus.HWInt = 6'b100000;
    #1;
    chk("im_hit", {31'd0, bus.IntReq}, 32'd1);
    bus.HWInt = 6'b000000;
    #1;
    chk("im_idle", {31'd0, bus.IntReq}, 32'd0);

    // A clean mid-run reset returns everything to zero.
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd(5'd12, 32'd0, "rst2_sr");
    rd(5'd14, 32'd0, "rst2_epc");
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
